// File: rtl/ram_rsp_fifo.sv
// Response FIFO for the RAM port controller: registered head entry, count
// output used by the read-credit logic. Storage is not reset, only pointers.
module ram_rsp_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic                          rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [$clog2(DEPTH+1)-1:0]    count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign rsp_valid = (count_q != '0);
   assign rsp_rdata = mem_q[rd_ptr_q];
   assign count     = count_q;
endmodule

// File: rtl/ram_sync_port_ctrl.sv
// Request/response front end for a synchronous RAM with optional output
// register: writes pass straight through, reads are credit-limited so the
// response FIFO can never overflow.
module ram_sync_port_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int OUTPUT_REG = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   output logic [ADDR_WIDTH-1:0]   ram_waddr,
   output logic                    ram_wvalid,
   output logic [DATA_WIDTH/8-1:0] ram_wstrb,
   output logic [ADDR_WIDTH-1:0]   ram_raddr,
   output logic                    ram_rvalid,
   output logic                    ram_oreg_cen,
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);
   localparam int LAT       = 1 + OUTPUT_REG;
   localparam int RSP_DEPTH = LAT + 1;
   localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
   localparam int OCC_W     = CNT_W + 1;

   logic [LAT-1:0]   rd_vld_q, rd_vld_d;
   logic [CNT_W-1:0] rsp_count;
   logic [OCC_W-1:0] inflight;
   logic [OCC_W-1:0] occupancy;
   logic             fifo_valid;
   logic             rsp_pop;
   logic             credit_ok;
   logic             accept;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) inflight = inflight + OCC_W'(rd_vld_q[i]);
   end

   // A pop in this cycle frees its slot in time for a read accepted now,
   // which is what allows one read per cycle with rsp_ready held high.
   assign rsp_pop   = fifo_valid & rsp_ready;
   assign occupancy = OCC_W'(rsp_count) + inflight - OCC_W'(rsp_pop);
   assign credit_ok = (occupancy < OCC_W'(RSP_DEPTH));
   assign req_ready = rst_n & (req_we | credit_ok);
   assign accept    = req_valid & req_ready;

   assign ram_wvalid = accept & req_we;
   assign ram_rvalid = accept & ~req_we;
   assign ram_waddr  = req_addr;
   assign ram_raddr  = req_addr;
   assign ram_wdata  = req_wdata;
   assign ram_wstrb  = req_wstrb;

   always_comb begin
      rd_vld_d    = '0;
      rd_vld_d[0] = ram_rvalid;
      for (int i = 1; i < LAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_vld_q <= '0;
      else        rd_vld_q <= rd_vld_d;
   end

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         assign ram_oreg_cen = rst_n & rd_vld_q[0];
      end else begin : g_no_oreg
         assign ram_oreg_cen = 1'b0;
      end
   endgenerate

   ram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_vld_q[LAT-1]),
      .push_data (ram_rdata),
      .pop       (rsp_pop),
      .rsp_valid (fifo_valid),
      .rsp_rdata (rsp_rdata),
      .count     (rsp_count)
   );

   assign rsp_valid = rst_n & fifo_valid;
endmodule

// File: tb/tb_ram_sync_port_ctrl.sv
// Bench for ram_sync_port_ctrl: one instance without and one with the RAM
// output register, each with its own RAM model and outstanding-read model.
module tb_ram_sync_port_ctrl;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]    req_valid, req_we, rsp_ready;
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic [SW-1:0] req_wstrb [2];
   wire  [1:0]    req_ready, rsp_valid, ram_wvalid, ram_rvalid, ram_oreg_cen;
   wire  [DW-1:0] rsp_rdata [2];
   wire  [DW-1:0] ram_wdata [2];
   wire  [DW-1:0] ram_rdata [2];
   wire  [AW-1:0] ram_waddr [2];
   wire  [AW-1:0] ram_raddr [2];
   wire  [SW-1:0] ram_wstrb [2];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [SW-1:0] strb);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_env
      localparam int LATK  = g + 1;
      localparam int DEPTH = LATK + 1;

      ram_sync_port_ctrl #(
         .DATA_WIDTH (DW),
         .ADDR_WIDTH (AW),
         .OUTPUT_REG (g)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .req_valid    (req_valid[g]),
         .req_ready    (req_ready[g]),
         .req_we       (req_we[g]),
         .req_addr     (req_addr[g]),
         .req_wdata    (req_wdata[g]),
         .req_wstrb    (req_wstrb[g]),
         .rsp_valid    (rsp_valid[g]),
         .rsp_ready    (rsp_ready[g]),
         .rsp_rdata    (rsp_rdata[g]),
         .ram_wdata    (ram_wdata[g]),
         .ram_waddr    (ram_waddr[g]),
         .ram_wvalid   (ram_wvalid[g]),
         .ram_wstrb    (ram_wstrb[g]),
         .ram_raddr    (ram_raddr[g]),
         .ram_rvalid   (ram_rvalid[g]),
         .ram_oreg_cen (ram_oreg_cen[g]),
         .ram_rdata    (ram_rdata[g])
      );

      // synchronous RAM: registered read, optional output register
      logic [DW-1:0] ram_mem [256];
      logic [DW-1:0] rd_s0, rd_s1;
      always @(posedge clk) begin
         if (ram_wvalid[g]) ram_mem[ram_waddr[g]] <= merge(ram_mem[ram_waddr[g]], ram_wdata[g], ram_wstrb[g]);
         if (ram_rvalid[g]) rd_s0 <= ram_mem[ram_raddr[g]];
         if (ram_oreg_cen[g]) rd_s1 <= rd_s0;
      end
      assign ram_rdata[g] = (g == 1) ? rd_s1 : rd_s0;

      // reference: every accepted read owes one response, ready LAT+1 cycles later, in order
      logic [DW-1:0] model_mem [256];
      logic [DW-1:0] exp_q [$];
      int            rdy_q [$];
      int            cyc = 0;
      int            rsp_cnt = 0;
      bit            exp_rv, exp_rr, pop, acc;

      always @(negedge clk) begin
         cyc++;
         if (!rst_n) begin
            chk($sformatf("k%0d rst req_ready", g), req_ready[g], 0);
            chk($sformatf("k%0d rst rsp_valid", g), rsp_valid[g], 0);
            chk($sformatf("k%0d rst ram_wvalid", g), ram_wvalid[g], 0);
            chk($sformatf("k%0d rst ram_rvalid", g), ram_rvalid[g], 0);
            chk($sformatf("k%0d rst ram_oreg_cen", g), ram_oreg_cen[g], 0);
            exp_q.delete();
            rdy_q.delete();
         end else begin
            exp_rv = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
            chk($sformatf("k%0d rsp_valid", g), rsp_valid[g], exp_rv);
            if (exp_rv) chk($sformatf("k%0d rsp_rdata", g), rsp_rdata[g], exp_q[0]);
            pop    = exp_rv && rsp_ready[g];
            exp_rr = req_we[g] || ((exp_q.size() - int'(pop)) < DEPTH);
            chk($sformatf("k%0d req_ready", g), req_ready[g], exp_rr);
            acc = req_valid[g] && exp_rr;
            chk($sformatf("k%0d ram_wvalid", g), ram_wvalid[g], acc && req_we[g]);
            chk($sformatf("k%0d ram_rvalid", g), ram_rvalid[g], acc && !req_we[g]);
            if (g == 0) chk("k0 ram_oreg_cen", ram_oreg_cen[g], 0);
            if (pop) begin
               void'(exp_q.pop_front());
               void'(rdy_q.pop_front());
               rsp_cnt++;
            end
            if (acc) begin
               if (req_we[g]) begin
                  model_mem[req_addr[g]] = merge(model_mem[req_addr[g]], req_wdata[g], req_wstrb[g]);
               end else begin
                  exp_q.push_back(model_mem[req_addr[g]]);
                  rdy_q.push_back(cyc + LATK + 1);
               end
            end
         end
      end
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t tbl [12];

   // Drive one request from the phase just after a rising edge; returns one edge after acceptance.
   task automatic issue(input int k, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] ws);
      int n = 0;
      bit ok = 0;
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wd;
      req_wstrb[k] = ws;
      while (!ok && n < 50) begin
         @(negedge clk);
         if (req_ready[k]) ok = 1;
         @(posedge clk); #1;
         n++;
      end
      req_valid[k] = 1'b0;
      if (!ok) chk($sformatf("k%0d issue accepted", k), 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int lat, got, acc, before0, before1;
      bit a;
      tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 8'h20, 32'hDEADBEEF, 4'hF, 32'h0};
      tbl[3]  = '{1'b1, 8'h20, 32'h0000CAFE, 4'h3, 32'h0};
      tbl[4]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'hDEADCAFE};
      tbl[5]  = '{1'b1, 8'h30, 32'hAABBCCDD, 4'hF, 32'h0};
      tbl[6]  = '{1'b1, 8'h30, 32'h11223344, 4'hA, 32'h0};
      tbl[7]  = '{1'b0, 8'h30, 32'h0,        4'h0, 32'h11BB33DD};
      tbl[8]  = '{1'b1, 8'hFF, 32'h12345678, 4'hF, 32'h0};
      tbl[9]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'h12345678};
      tbl[10] = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 32'h0};
      tbl[11] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0BADF00D};

      rst_n = 1'b0;
      req_valid = '0; req_we = '0; rsp_ready = 2'b11;
      for (int k = 0; k < 2; k++) begin
         req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // fill every word of both RAMs so later reads have known contents
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = AW'(i);
            req_wdata[k] = (i == 0) ? 32'h0BADF00D : $urandom; req_wstrb[k] = 4'hF;
         end
         idle(1);
      end
      req_valid = '0;
      idle(2);

      // directed table, including read right after write and a no-strobe write
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 12; i++) begin
            issue(k, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
            if (!tbl[i].we) begin
               lat = 1; got = 0;
               while (!got && lat < 20) begin
                  @(negedge clk);
                  if (rsp_valid[k]) begin
                     got = 1;
                     chk($sformatf("k%0d tbl%0d rdata", k, i), rsp_rdata[k], tbl[i].exp);
                  end else lat++;
                  @(posedge clk); #1;
               end
               chk($sformatf("k%0d tbl%0d latency", k, i), lat, k + 2);
            end
         end
      end
      idle(3);

      // backpressure with output register: exactly RSP_DEPTH reads accepted
      rsp_ready[1] = 1'b0; req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 8'h40;
      acc = 0;
      repeat (8) begin
         @(negedge clk); a = req_ready[1];
         @(posedge clk); #1;
         if (a) begin acc++; req_addr[1] = 8'h40 + AW'(acc); end
      end
      chk("k1 stalled accept count", acc, 3);
      @(negedge clk);
      chk("k1 stalled req_ready", req_ready[1], 0);
      @(posedge clk); #1;
      req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
      got = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid[1]) begin
            chk($sformatf("k1 stalled rsp%0d", got), rsp_rdata[1], g_env[1].model_mem[8'h40 + got]);
            got++;
         end
         @(posedge clk); #1;
      end
      chk("k1 stalled rsp count", got, 3);

      // full-rate reads
      for (int k = 0; k < 2; k++) begin
         acc = 0;
         for (int i = 0; i < 64; i++) begin
            req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = AW'($urandom_range(0, 255));
            @(negedge clk); if (req_ready[k]) acc++;
            @(posedge clk); #1;
         end
         req_valid[k] = 1'b0;
         chk($sformatf("k%0d streaming accepts", k), acc, 64);
         idle(6);
      end
      chk("k0 stream drained", g_env[0].exp_q.size(), 0);
      chk("k1 stream drained", g_env[1].exp_q.size(), 0);

      // random mixed traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            req_valid[k] = ($urandom_range(0, 3) != 0);
            req_we[k]    = ($urandom_range(0, 2) == 0);
            req_addr[k]  = AW'($urandom_range(0, 15));
            req_wdata[k] = $urandom;
            req_wstrb[k] = SW'($urandom_range(0, 15));
            rsp_ready[k] = ($urandom_range(0, 3) != 0);
         end
         idle(1);
      end
      req_valid = '0; rsp_ready = 2'b11;
      idle(8);
      chk("k0 random drained", g_env[0].exp_q.size(), 0);
      chk("k1 random drained", g_env[1].exp_q.size(), 0);

      // reset with two reads outstanding
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 8'h10;
      end
      idle(1);
      req_addr[0] = 8'h20; req_addr[1] = 8'h20;
      idle(1);
      chk("k0 pre-reset rsp_valid", rsp_valid[0], 1);
      rst_n = 1'b0;
      #1;
      chk("k0 async rsp_valid drop", rsp_valid[0], 0);
      chk("k1 async rsp_valid drop", rsp_valid[1], 0);
      chk("k0 async req_ready drop", req_ready[0], 0);
      chk("k1 async ram_rvalid drop", ram_rvalid[1], 0);
      chk("k1 async oreg_cen drop", ram_oreg_cen[1], 0);
      idle(2);
      req_valid = '0;
      rst_n = 1'b1;
      before0 = g_env[0].rsp_cnt;
      before1 = g_env[1].rsp_cnt;
      idle(10);
      chk("k0 no rsp after reset", g_env[0].rsp_cnt, before0);
      chk("k1 no rsp after reset", g_env[1].rsp_cnt, before1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
